// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: multi-wide push, in-order multi-lane registered pop.
// Optional same-edge bypass into the output lanes when empty: define DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int fetchWidth              = 4,
  parameter int decodeWidth             = 2,
  parameter int queueDepth              = 16
) (
  input  logic                                        clock_i,
  input  logic                                        reset_i,
  input  logic                                        enable_i,
  input  logic                                        flush_i,
  input  logic                                        stall_i,
  input  logic [fetchWidth*instructionWidth-1:0]      instructions_i,
  input  logic [$clog2(fetchWidth+1)-1:0]             validCount_i,
  input  logic [addressWidth-1:0]                     instructionAddress_i,
  input  logic [instructionCounterWidth-1:0]          instructionMajId_i,
  input  logic                                        is64Bit_i,
  input  logic [PidSize-1:0]                          instructionPid_i,
  input  logic [TidSize-1:0]                          instructionTid_i,
  output logic                                        pushAcceptOut,
  output logic [$clog2(queueDepth+1)-1:0]             freeSlotsOut,
  output logic [decodeWidth-1:0]                      enableOut,
  output logic [decodeWidth*instructionWidth-1:0]     instructionOut,
  output logic [decodeWidth*addressWidth-1:0]         addressOut,
  output logic [decodeWidth*instructionCounterWidth-1:0] majIDOut,
  output logic [decodeWidth-1:0]                      is64BitOut,
  output logic [decodeWidth*PidSize-1:0]              pidOut,
  output logic [decodeWidth*TidSize-1:0]              tidOut
);

  localparam int FSW  = $clog2(queueDepth + 1);
  localparam int PTRW = $clog2(queueDepth);
  localparam int MAXW = (fetchWidth > decodeWidth) ? fetchWidth : decodeWidth;

  typedef struct packed {
    logic [instructionWidth-1:0]        ins;
    logic [addressWidth-1:0]            addr;
    logic [instructionCounterWidth-1:0] mid;
    logic                               b64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
  } entry_t;

  entry_t           mem [queueDepth];
  entry_t           lane_in [MAXW];
  entry_t           out_nxt [decodeWidth];
  logic [decodeWidth-1:0] en_nxt;
  logic [PTRW-1:0]  rd_ptr, wr_ptr;
  logic [FSW-1:0]   count;
  logic [FSW-1:0]   pop_n, byp_n, push_buf, popped;
  logic             pop_go;

  always_comb begin
    for (int unsigned k = 0; k < MAXW; k++) begin
      lane_in[k] = '0;
      if (k < fetchWidth) begin
        lane_in[k].ins  = instructions_i[k*instructionWidth +: instructionWidth];
        lane_in[k].addr = instructionAddress_i + addressWidth'(4 * k);
        lane_in[k].mid  = instructionMajId_i + instructionCounterWidth'(k);
        lane_in[k].b64  = is64Bit_i;
        lane_in[k].pid  = instructionPid_i;
        lane_in[k].tid  = instructionTid_i;
      end
    end
  end

  assign freeSlotsOut  = FSW'(queueDepth) - count;
  assign pushAcceptOut = enable_i & ~flush_i & ~reset_i & (validCount_i != '0) &
                         (FSW'(validCount_i) <= freeSlotsOut);
  assign pop_go = enable_i & ~stall_i;
  assign pop_n  = (count < FSW'(decodeWidth)) ? count : FSW'(decodeWidth);

`ifdef DECODE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = pushAcceptOut & pop_go & (count == '0);
  assign byp_n  = !bypass ? '0 :
                  (FSW'(validCount_i) < FSW'(decodeWidth)) ? FSW'(validCount_i) : FSW'(decodeWidth);
`else
  assign byp_n = '0;
`endif

  // Bypassed lanes never occupy the buffer; pop_n is 0 whenever bypass fires.
  assign push_buf = pushAcceptOut ? FSW'(validCount_i) - byp_n : '0;
  assign popped   = pop_go ? pop_n : '0;

  always_comb begin
    for (int unsigned i = 0; i < decodeWidth; i++) begin
      out_nxt[i] = '0;
      en_nxt[i]  = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
      if (bypass) begin
        if (FSW'(i) < byp_n) begin
          out_nxt[i] = lane_in[i];
          en_nxt[i]  = 1'b1;
        end
      end else
`endif
      if (FSW'(i) < pop_n) begin
        out_nxt[i] = mem[rd_ptr + PTRW'(i)];
        en_nxt[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    for (int unsigned k = 0; k < fetchWidth; k++) begin
      if (pushAcceptOut && FSW'(k) >= byp_n && FSW'(k) < FSW'(validCount_i))
        mem[wr_ptr + PTRW'(k) - PTRW'(byp_n)] <= lane_in[k];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      enableOut      <= '0;
      instructionOut <= '0;
      addressOut     <= '0;
      majIDOut       <= '0;
      is64BitOut     <= '0;
      pidOut         <= '0;
      tidOut         <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTRW'(push_buf);
      count  <= count + push_buf - popped;
      if (pop_go) begin
        rd_ptr    <= rd_ptr + PTRW'(pop_n);
        enableOut <= en_nxt;
        for (int unsigned i = 0; i < decodeWidth; i++) begin
          instructionOut[i*instructionWidth +: instructionWidth]         <= out_nxt[i].ins;
          addressOut[i*addressWidth +: addressWidth]                     <= out_nxt[i].addr;
          majIDOut[i*instructionCounterWidth +: instructionCounterWidth] <= out_nxt[i].mid;
          is64BitOut[i]                                                  <= out_nxt[i].b64;
          pidOut[i*PidSize +: PidSize]                                   <= out_nxt[i].pid;
          tidOut[i*TidSize +: TidSize]                                   <= out_nxt[i].tid;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with a scoreboard of pushed-but-not-yet-presented instructions.
// Honours DECODE_QUEUE_BYPASS_EN to match the DUT build.
module tb_decode_queue;

  logic         clk = 1'b0;
  logic         rst, ena, fl, st;
  logic [2:0]   vc;
  logic [127:0] iw;
  logic [63:0]  ia, im;
  logic         b64;
  logic [19:0]  pid;
  logic [15:0]  tid;

  logic         pushAcceptOut;
  logic [4:0]   freeSlotsOut;
  logic [1:0]   enableOut;
  logic [63:0]  instructionOut;
  logic [127:0] addressOut, majIDOut;
  logic [1:0]   is64BitOut;
  logic [39:0]  pidOut;
  logic [31:0]  tidOut;

  decode_queue #(
    .addressWidth(64), .instructionWidth(32), .PidSize(20), .TidSize(16),
    .instructionCounterWidth(64), .fetchWidth(4), .decodeWidth(2), .queueDepth(16)
  ) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(ena), .flush_i(fl), .stall_i(st),
    .instructions_i(iw), .validCount_i(vc), .instructionAddress_i(ia),
    .instructionMajId_i(im), .is64Bit_i(b64), .instructionPid_i(pid),
    .instructionTid_i(tid), .pushAcceptOut(pushAcceptOut), .freeSlotsOut(freeSlotsOut),
    .enableOut(enableOut), .instructionOut(instructionOut), .addressOut(addressOut),
    .majIDOut(majIDOut), .is64BitOut(is64BitOut), .pidOut(pidOut), .tidOut(tidOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] addr;
    logic [63:0] mid;
    logic        b64;
    logic [19:0] pid;
    logic [15:0] tid;
  } ent_t;

  ent_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0]  base_addr, base_mid;
  logic [1:0]   e_en;
  logic [63:0]  e_ins;
  logic [127:0] e_addr, e_mid;
  logic [1:0]   e_b64;
  logic [39:0]  e_pid;
  logic [31:0]  e_tid;

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return {a[15:0], ~a[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_en = '0; e_ins = '0; e_addr = '0; e_mid = '0; e_b64 = '0; e_pid = '0; e_tid = '0;
  endtask

  task automatic do_pop();
    ent_t e;
    int unsigned n;
    clear_exp();
    n = (sb.size() < 2) ? sb.size() : 2;
    for (int unsigned i = 0; i < n; i++) begin
      e = sb.pop_front();
      e_en[i]           = 1'b1;
      e_ins[i*32 +: 32] = e.ins;
      e_addr[i*64 +: 64] = e.addr;
      e_mid[i*64 +: 64] = e.mid;
      e_b64[i]          = e.b64;
      e_pid[i*20 +: 20] = e.pid;
      e_tid[i*16 +: 16] = e.tid;
    end
  endtask

  task automatic push_model();
    ent_t e;
    for (int unsigned k = 0; k < vc; k++) begin
      e.addr = base_addr + 64'(4 * k);
      e.mid  = base_mid + 64'(k);
      e.ins  = ins_of(e.addr);
      e.b64  = b64;
      e.pid  = pid;
      e.tid  = tid;
      sb.push_back(e);
    end
    base_addr = base_addr + 64'(4 * vc);
    base_mid  = base_mid + 64'(vc);
  endtask

  task automatic cycle();
    logic acc, pop, byp;
    for (int unsigned k = 0; k < 4; k++) iw[k*32 +: 32] = ins_of(base_addr + 64'(4 * k));
    ia  = base_addr;
    im  = base_mid;
    pid = base_mid[19:0] ^ 20'hABCDE;
    tid = base_addr[17:2];
    b64 = base_mid[1];
    #1;
    acc = ena && !fl && !rst && (vc != 0) && (int'(vc) <= 16 - sb.size());
    chk("accept", 256'(pushAcceptOut), 256'(acc));
    if (rst || fl) begin
      sb.delete();
      clear_exp();
    end else begin
      pop = ena && !st;
      byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
      byp = pop && acc && (sb.size() == 0);
`endif
      if (byp) begin
        push_model();
        do_pop();
      end else begin
        if (pop) do_pop();
        if (acc) push_model();
      end
    end
    @(posedge clk);
    #1;
    chk("enable", 256'(enableOut), 256'(e_en));
    chk("instr", 256'(instructionOut), 256'(e_ins));
    chk("addr", 256'(addressOut), 256'(e_addr));
    chk("majid", 256'(majIDOut), 256'(e_mid));
    chk("is64", 256'(is64BitOut), 256'(e_b64));
    chk("pid", 256'(pidOut), 256'(e_pid));
    chk("tid", 256'(tidOut), 256'(e_tid));
    chk("free", 256'(freeSlotsOut), 256'(16 - sb.size()));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; fl = 1'b0; st = 1'b0; vc = 3'd0;
    iw = '0; ia = '0; im = '0; b64 = 1'b0; pid = '0; tid = '0;
    base_addr = 64'h100; base_mid = 64'd10;
    clear_exp();
    cycle();
    chk("reset_free", 256'(freeSlotsOut), 256'(16));
    rst = 1'b0;

    // steady 4-wide push, 2-wide drain: fills until pushes start bouncing
    ena = 1'b1; vc = 3'd4;
    repeat (12) cycle();

    // enable low freezes both sides
    ena = 1'b0;
    repeat (2) cycle();
    ena = 1'b1;

    // full boundary under stall: 14 occupied, push 3 rejected, push 2 fills
    vc = 3'd0; fl = 1'b1; cycle(); fl = 1'b0;
    st = 1'b1; vc = 3'd4;
    repeat (3) cycle();
    vc = 3'd2; cycle();
    chk("occ14_free", 256'(freeSlotsOut), 256'(2));
    vc = 3'd3; cycle();
    vc = 3'd2; cycle();
    chk("full_free", 256'(freeSlotsOut), 256'(0));
    vc = 3'd4; cycle();
    st = 1'b0; vc = 3'd0;
    repeat (9) cycle();

    // stall with occupancy 1, then release
    st = 1'b1; vc = 3'd1; cycle();
    vc = 3'd0;
    repeat (5) cycle();
    st = 1'b0; cycle();
    chk("stall_release_en", 256'(enableOut), 256'(2'b01));
    cycle();

    // flush with a valid push while stalled at occupancy 9
    st = 1'b1; vc = 3'd4;
    repeat (2) cycle();
    vc = 3'd1; cycle();
    chk("occ9_free", 256'(freeSlotsOut), 256'(7));
    vc = 3'd4; fl = 1'b1; cycle();
    fl = 1'b0; vc = 3'd0;
    chk("flush_en", 256'(enableOut), 256'(0));
    chk("flush_free", 256'(freeSlotsOut), 256'(16));
    st = 1'b0; cycle();

    // push 3 into an empty queue at 0x200
    base_addr = 64'h200; vc = 3'd3; cycle();
    vc = 3'd0;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("byp_en", 256'(enableOut), 256'(2'b11));
    chk("byp_addr", 256'(addressOut), 256'({64'h204, 64'h200}));
    chk("byp_free", 256'(freeSlotsOut), 256'(15));
`else
    chk("nobyp_en", 256'(enableOut), 256'(0));
    chk("nobyp_free", 256'(freeSlotsOut), 256'(13));
    cycle();
    chk("nobyp_addr", 256'(addressOut), 256'({64'h204, 64'h200}));
    chk("nobyp_free2", 256'(freeSlotsOut), 256'(15));
`endif
    repeat (2) cycle();

    // address and major-id wrap across lanes
    base_addr = 64'hFFFF_FFFF_FFFF_FFF8; base_mid = 64'hFFFF_FFFF_FFFF_FFFE;
    vc = 3'd4; cycle();
    vc = 3'd0;
    repeat (3) cycle();

    // mixed push widths and stalls
    for (int i = 0; i < 24; i++) begin
      vc = 3'($urandom_range(0, 4));
      st = ($urandom_range(0, 3) == 0);
      cycle();
    end
    st = 1'b0; vc = 3'd0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
